// File: rtl/aes_pkg.sv
// Shared AES constants, the key-schedule FSM state type and the round-constant lookup.
// Used by the key expander and the round-encode datapath.
package aes_pkg;

  localparam int KEY_W     = 128;
  localparam int WORD_W    = 32;
  localparam int BYTE_W    = 8;
  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // RCON[1] sits in the top byte, RCON[10] in the bottom byte.
  localparam logic [79:0] RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

  function automatic logic [BYTE_W-1:0] rcon(input logic [3:0] idx);
    logic [BYTE_W-1:0] val;
    val = '0;
    if (idx >= 4'd1 && idx <= 4'd10) begin
      val = RCON[8*(10 - int'(idx)) +: 8];
    end
    return val;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, 8 bits in, 8 bits out.
// Row = high nibble; within a row, column 0 is the most significant byte.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [127:0] SBOX_ROW [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [127:0] row;
  logic [3:0]   col_rev;

  always_comb begin
    row      = SBOX_ROW[in_byte[7:4]];
    col_rev  = ~in_byte[3:0];
    out_byte = row[{col_rev, 3'b000} +: 8];
  end

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule: expands a loaded key into rk0..rk10, one round key
// per clock, and serves any round key by index to the round engine.
module aes_key_expander
  import aes_pkg::*;
#(
  parameter int NR      = 10,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [KEY_W-1:0] iKEY,
  input  logic             iKEY_LOAD,
  input  logic [3:0]       iRK_SEL,
  output logic [KEY_W-1:0] oROUND_KEY,
  output logic             oBUSY,
  output logic             oKEY_READY
);

  generate
    if (NR != NR_AES128) begin : g_nr_check
      $error("aes_key_expander supports only NR=10 (AES-128)");
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic               busy_reg, busy_next;
  logic               ready_reg, ready_next;
  logic [KEY_W-1:0]   rk_reg [0:NR_AES128];

  logic               wr_en;
  logic [3:0]         wr_idx;
  logic [KEY_W-1:0]   wr_data;

  logic [3:0]         prev_idx;
  logic [KEY_W-1:0]   prev_key;
  logic [WORD_W-1:0]  w0, w1, w2, w3;
  logic [WORD_W-1:0]  rot_word, sub_word;
  logic [WORD_W-1:0]  n0, n1, n2, n3;
  logic [KEY_W-1:0]   next_key;

  always_comb begin
    prev_idx = cnt_reg - 4'd1;
    prev_key = (prev_idx <= 4'd10) ? rk_reg[prev_idx] : '0;
    w0       = prev_key[127:96];
    w1       = prev_key[95:64];
    w2       = prev_key[63:32];
    w3       = prev_key[31:0];
    rot_word = {w3[23:0], w3[31:24]};
  end

  // SubWord: one S-box per byte of the rotated last word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .in_byte  (rot_word[BYTE_W*gi +: BYTE_W]),
        .out_byte (sub_word[BYTE_W*gi +: BYTE_W])
      );
    end
  endgenerate

  always_comb begin
    n0       = w0 ^ sub_word ^ {rcon(cnt_reg), 24'h0};
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // A load in any state restarts from rk0; partial keys are simply overwritten later.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    ready_next = ready_reg;
    wr_en      = 1'b0;
    wr_idx     = cnt_reg;
    wr_data    = next_key;
    if (iKEY_LOAD) begin
      state_next = EXPAND;
      cnt_next   = 4'd1;
      busy_next  = 1'b1;
      ready_next = 1'b0;
      wr_en      = 1'b1;
      wr_idx     = 4'd0;
      wr_data    = iKEY;
    end else begin
      case (state_reg)
        EXPAND: begin
          wr_en = 1'b1;
          if (cnt_reg == 4'(NR_AES128)) begin
            state_next = READY;
            cnt_next   = 4'd0;
            busy_next  = 1'b0;
            ready_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b0;
      for (int i = 0; i <= NR_AES128; i++) begin
        rk_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
      ready_reg <= ready_next;
      if (wr_en) begin
        rk_reg[wr_idx] <= wr_data;
      end
    end
  end

  assign oBUSY      = busy_reg;
  assign oKEY_READY = ready_reg;

  logic [KEY_W-1:0] sel_key;
  assign sel_key = (iRK_SEL <= 4'd10) ? rk_reg[iRK_SEL] : '0;

  generate
    if (REG_OUT) begin : g_reg_out
      logic [KEY_W-1:0] rd_reg;
      // Same-edge write and read of one index returns the pre-write value.
      always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
          rd_reg <= '0;
        end else begin
          rd_reg <= sel_key;
        end
      end
      assign oROUND_KEY = rd_reg;
    end else begin : g_comb_out
      assign oROUND_KEY = sel_key;
    end
  endgenerate

endmodule
